// File: rtl/soc_system_switches_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_switches_pio_irq
// Purpose  : Input PIO for the HPS lightweight bridge. Each input bit is
//            synchronised, debounced and edge-detected. Detected edges are
//            latched in a write-1-to-clear register, and a maskable level
//            interrupt is raised while any unmasked captured edge is pending.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            address    - register word select (0 DATA, 1 IRQMASK,
//                         2 EDGECAPTURE, 3 RAW)
//            chipselect - slave select, qualifies write_n
//            write_n    - active-low write strobe
//            writedata  - write data
//            readdata   - registered read data, 1-cycle latency
//            in_port    - raw asynchronous switch inputs
//            irq        - level interrupt, active high
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_switches_pio_irq #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_addr_data = 2'd0;
  localparam logic [1:0] c_addr_mask = 2'd1;
  localparam logic [1:0] c_addr_edge = 2'd2;
  localparam logic [1:0] c_addr_raw  = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecapture;
  logic [WIDTH-1:0] w_edge;
  logic             w_wr;
  logic             w_mask_hit;
  logic             w_w1c_hit;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Upper write-data bits have no destination when WIDTH < 32.
  assign w_unused_wdata = ^writedata;

  assign w_wr       = chipselect & ~write_n;
  assign w_mask_hit = w_wr & (address == c_addr_mask);
  assign w_w1c_hit  = w_wr & (address == c_addr_edge);

  // Synchroniser: stage 0 samples the pin, last stage feeds the debouncer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Per-bit debounce: a new level is accepted only after it has differed
  // from the current stable value for DEBOUNCE_CYCLES consecutive clocks.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt       <= '0;
          r_stable[i] <= 1'b0;
        end else if (w_sync[i] == r_stable[i]) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_stable[i] <= w_sync[i];
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  endgenerate

  // Edge selection is fixed at elaboration time.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge = r_stable & ~r_stable_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge = ~r_stable & r_stable_d;
    end else begin : g_any
      assign w_edge = r_stable ^ r_stable_d;
    end
  endgenerate

  // A new edge takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d    <= '0;
      r_irqmask     <= '0;
      r_edgecapture <= '0;
    end else begin
      r_stable_d    <= r_stable;
      r_edgecapture <= w_edge |
                       (r_edgecapture & ~({WIDTH{w_w1c_hit}} & writedata[WIDTH-1:0]));
      if (w_mask_hit) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_addr_data: w_rd_mux = 32'(r_stable);
      c_addr_mask: w_rd_mux = 32'(r_irqmask);
      c_addr_edge: w_rd_mux = 32'(r_edgecapture);
      c_addr_raw:  w_rd_mux = 32'(w_sync);
      default:     w_rd_mux = '0;
    endcase
  end

  // Read data is refreshed every clock from pre-write register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edgecapture & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_switches_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_switches_pio_irq
// Purpose  : Directed self-checking bench. dut0 uses the default rising-edge
//            configuration; dut1 uses EDGE_TYPE=2 (any edge) and shares the
//            bus signals but has its own input port and outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_switches_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic [9:0]  in_port;
  logic [9:0]  in_port2;
  logic        irq;
  logic        irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_switches_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  soc_system_switches_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 10'h000;
    in_port2   = 10'h000;
    repeat (3) tick();
    reset_n = 1'b1;

    // 1: reset state
    rd(2'd0); chk("rst_data", readdata, 32'h0);
    rd(2'd1); chk("rst_mask", readdata, 32'h0);
    rd(2'd2); chk("rst_edge", readdata, 32'h0);
    rd(2'd3); chk("rst_raw",  readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // 2: held pattern through synchroniser and debounce
    address = 2'd3;
    in_port = 10'h2A5;
    tick(); tick();
    chk("raw_early", readdata, 32'h0);
    tick();
    chk("raw", readdata, 32'h2A5);
    address = 2'd0;
    tick(); tick(); tick();
    chk("data_early", readdata, 32'h0);
    tick();
    chk("data", readdata, 32'h2A5);
    rd(2'd2); chk("edge_2a5", readdata, 32'h2A5);
    chk("irq_unmasked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h3FF);
    rd(2'd2); chk("edge_cleared", readdata, 32'h0);

    // 3: three-cycle glitch on bit0 is rejected
    in_port = 10'h2A4;
    repeat (12) tick();
    wr(2'd2, 32'h3FF);
    in_port = 10'h2A5;
    repeat (3) tick();
    in_port = 10'h2A4;
    repeat (12) tick();
    rd(2'd0); chk("glitch_data", readdata, 32'h2A4);
    rd(2'd2); chk("glitch_edge", readdata, 32'h0);

    // 4: masked interrupt and W1C
    wr(2'd1, 32'hFFFF_FC01);
    rd(2'd1); chk("mask_rb", readdata, 32'h001);
    chk("irq_pre", {31'h0, irq}, 32'h0);
    in_port = 10'h2A5;
    repeat (6) tick();
    chk("irq_before_edge", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h001);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    rd(2'd2); chk("edge_w1c", readdata, 32'h0);

    // 5: W1C in the same cycle as the edge: set wins
    in_port = 10'h2A4;
    repeat (12) tick();
    in_port = 10'h2A5;
    repeat (6) tick();
    chk("irq_race_pre", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h001);
    chk("irq_race", {31'h0, irq}, 32'h1);
    rd(2'd2); chk("edge_race", readdata, 32'h001);
    wr(2'd2, 32'h001);
    chk("irq_race_clr", {31'h0, irq}, 32'h0);

    // 6: any-edge instance captures both rise and fall
    in_port2 = 10'h008;
    repeat (10) tick();
    rd(2'd2); chk("any_rise", readdata2, 32'h008);
    chk("any_irq_masked", {31'h0, irq2}, 32'h0);
    wr(2'd2, 32'h3FF);
    rd(2'd2); chk("any_clr", readdata2, 32'h0);
    in_port2 = 10'h000;
    repeat (10) tick();
    rd(2'd2); chk("any_fall", readdata2, 32'h008);
    rd(2'd0); chk("any_data", readdata2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
